// File: rtl/load_store_buffer.sv
// In-order load/store queue: snoops CDB/ALU for operands, runs loads at the head,
// announces stores to the ROB and writes memory only after the ROB commits them.
module load_store_buffer #(
  parameter int unsigned LSB_SIZE   = 8,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned VAL_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  issue_valid,
  input  logic                  issue_is_store,
  input  logic [2:0]            issue_funct3,
  input  logic [ID_WIDTH-1:0]   issue_tag,
  input  logic [VAL_WIDTH-1:0]  issue_imm,
  input  logic                  issue_ready1,
  input  logic                  issue_ready2,
  input  logic [VAL_WIDTH-1:0]  issue_val1,
  input  logic [VAL_WIDTH-1:0]  issue_val2,
  input  logic [ID_WIDTH-1:0]   issue_lab1,
  input  logic [ID_WIDTH-1:0]   issue_lab2,
  output logic                  lsbFull,
  input  logic                  cdbReady,
  input  logic [ID_WIDTH-1:0]   cdb2lab,
  input  logic [VAL_WIDTH-1:0]  cdb2val,
  input  logic                  aluReady,
  input  logic [ID_WIDTH-1:0]   entry_in,
  input  logic [VAL_WIDTH-1:0]  val_in,
  input  logic                  commit_valid,
  input  logic [ID_WIDTH-1:0]   commit_lab,
  output logic                  st_ready,
  output logic [ID_WIDTH-1:0]   st_lab,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [VAL_WIDTH-1:0]  mem_wdata,
  output logic [1:0]            mem_size,
  input  logic                  mem_done,
  input  logic [VAL_WIDTH-1:0]  mem_rdata,
  output logic                  lsb_ready,
  output logic [ID_WIDTH-1:0]   lsb_lab,
  output logic [VAL_WIDTH-1:0]  lsb_val
);

  localparam int unsigned PtrW = $clog2(LSB_SIZE);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]     count_q, count_d, ccnt_q, ccnt_d;
  logic                drop_q, drop_d, busy_store_q, busy_store_d;

  logic                is_store_q [LSB_SIZE], is_store_d [LSB_SIZE];
  logic [2:0]          funct3_q [LSB_SIZE], funct3_d [LSB_SIZE];
  logic [ID_WIDTH-1:0] tag_q [LSB_SIZE], tag_d [LSB_SIZE];
  logic [VAL_WIDTH-1:0] imm_q [LSB_SIZE], imm_d [LSB_SIZE];
  logic                rdy1_q [LSB_SIZE], rdy1_d [LSB_SIZE], rdy2_q [LSB_SIZE], rdy2_d [LSB_SIZE];
  logic [VAL_WIDTH-1:0] val1_q [LSB_SIZE], val1_d [LSB_SIZE], val2_q [LSB_SIZE], val2_d [LSB_SIZE];
  logic [ID_WIDTH-1:0] lab1_q [LSB_SIZE], lab1_d [LSB_SIZE], lab2_q [LSB_SIZE], lab2_d [LSB_SIZE];
  logic                announced_q [LSB_SIZE], announced_d [LSB_SIZE];
  logic                committed_q [LSB_SIZE], committed_d [LSB_SIZE];

  logic                  st_ready_q, st_ready_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic                  lsb_ready_q, lsb_ready_d;
  logic [ID_WIDTH-1:0]   st_lab_q, st_lab_d, lsb_lab_q, lsb_lab_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [VAL_WIDTH-1:0]  mem_wdata_q, mem_wdata_d, lsb_val_q, lsb_val_d, ext_val;
  logic [1:0]            mem_size_q, mem_size_d;

  logic [LSB_SIZE-1:0] live;
  logic                push, pop, pop_store, commit_hit;

  assign lsbFull = (count_q == CntW'(LSB_SIZE));

  always_comb begin
    for (int i = 0; i < LSB_SIZE; i++) begin
      live[i] = ({1'b0, PtrW'(i) - head_q} < count_q);
    end
  end

  always_comb begin
    unique case (funct3_q[head_q])
      3'b000:  ext_val = {{(VAL_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_val = {{(VAL_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ext_val = {{(VAL_WIDTH-8){1'b0}}, mem_rdata[7:0]};
      3'b101:  ext_val = {{(VAL_WIDTH-16){1'b0}}, mem_rdata[15:0]};
      default: ext_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;   drop_d = drop_q;     busy_store_d = busy_store_q;
    is_store_d = is_store_q; funct3_d = funct3_q; tag_d = tag_q; imm_d = imm_q;
    rdy1_d = rdy1_q; val1_d = val1_q; lab1_d = lab1_q;
    rdy2_d = rdy2_q; val2_d = val2_q; lab2_d = lab2_q;
    announced_d = announced_q; committed_d = committed_q;
    st_ready_d = 1'b0;   st_lab_d = st_lab_q;  lsb_ready_d = 1'b0;
    lsb_lab_d = lsb_lab_q; lsb_val_d = lsb_val_q;
    mem_req_d = mem_req_q; mem_we_d = mem_we_q; mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q; mem_size_d = mem_size_q;
    push = issue_valid && !lsbFull && !flush_in;
    pop = 1'b0; pop_store = 1'b0; commit_hit = 1'b0;

    if (!flush_in) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (live[i]) begin
          if (!rdy1_q[i] && cdbReady && cdb2lab == lab1_q[i]) begin
            rdy1_d[i] = 1'b1; val1_d[i] = cdb2val;
          end else if (!rdy1_q[i] && aluReady && entry_in == lab1_q[i]) begin
            rdy1_d[i] = 1'b1; val1_d[i] = val_in;
          end
          if (!rdy2_q[i] && cdbReady && cdb2lab == lab2_q[i]) begin
            rdy2_d[i] = 1'b1; val2_d[i] = cdb2val;
          end else if (!rdy2_q[i] && aluReady && entry_in == lab2_q[i]) begin
            rdy2_d[i] = 1'b1; val2_d[i] = val_in;
          end
          if (commit_valid && is_store_q[i] && !committed_q[i] && tag_q[i] == commit_lab) begin
            committed_d[i] = 1'b1; commit_hit = 1'b1;
          end
        end
      end
    end

    if (push) begin
      is_store_d[tail_q] = issue_is_store; funct3_d[tail_q] = issue_funct3;
      tag_d[tail_q] = issue_tag; imm_d[tail_q] = issue_imm;
      announced_d[tail_q] = 1'b0; committed_d[tail_q] = 1'b0;
      lab1_d[tail_q] = issue_lab1; lab2_d[tail_q] = issue_lab2;
      rdy1_d[tail_q] = 1'b1; rdy2_d[tail_q] = 1'b1;
      if (issue_ready1) val1_d[tail_q] = issue_val1;
      else if (cdbReady && cdb2lab == issue_lab1) val1_d[tail_q] = cdb2val;
      else if (aluReady && entry_in == issue_lab1) val1_d[tail_q] = val_in;
      else rdy1_d[tail_q] = 1'b0;
      if (issue_ready2) val2_d[tail_q] = issue_val2;
      else if (cdbReady && cdb2lab == issue_lab2) val2_d[tail_q] = cdb2val;
      else if (aluReady && entry_in == issue_lab2) val2_d[tail_q] = val_in;
      else rdy2_d[tail_q] = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (!flush_in && count_q != '0) begin
          if ((!is_store_q[head_q] && rdy1_q[head_q]) ||
              (is_store_q[head_q] && committed_q[head_q])) begin
            mem_req_d    = 1'b1;
            mem_we_d     = is_store_q[head_q];
            mem_addr_d   = ADDR_WIDTH'(val1_q[head_q] + imm_q[head_q]);
            mem_size_d   = funct3_q[head_q][1:0];
            state_d      = StBusy;
            busy_store_d = is_store_q[head_q];
            drop_d       = 1'b0;
            if (is_store_q[head_q]) mem_wdata_d = val2_q[head_q];
          end else if (is_store_q[head_q] && rdy1_q[head_q] && rdy2_q[head_q] &&
                       !announced_q[head_q]) begin
            st_ready_d = 1'b1;
            st_lab_d   = tag_q[head_q];
            announced_d[head_q] = 1'b1;
          end
        end
      end
      StBusy: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          drop_d    = 1'b0;
          if (busy_store_q) begin
            pop = 1'b1; pop_store = 1'b1;
          end else if (!drop_q && !flush_in) begin
            pop = 1'b1;
            lsb_ready_d = 1'b1;
            lsb_lab_d   = tag_q[head_q];
            lsb_val_d   = ext_val;
          end
        end else if (flush_in && !busy_store_q) begin
          // The in-flight load's entry is discarded; swallow its completion later.
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    head_d = head_q + PtrW'(pop);
    if (flush_in) begin
      tail_d  = head_q + ccnt_q[PtrW-1:0];
      count_d = ccnt_q - CntW'(pop);
    end else begin
      tail_d  = tail_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
    ccnt_d = ccnt_q + CntW'(commit_hit) - CntW'(pop_store);
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= StIdle; head_q <= '0; tail_q <= '0; count_q <= '0; ccnt_q <= '0;
      drop_q <= 1'b0; busy_store_q <= 1'b0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        is_store_q[i] <= 1'b0; funct3_q[i] <= '0; tag_q[i] <= '0; imm_q[i] <= '0;
        rdy1_q[i] <= 1'b0; val1_q[i] <= '0; lab1_q[i] <= '0;
        rdy2_q[i] <= 1'b0; val2_q[i] <= '0; lab2_q[i] <= '0;
        announced_q[i] <= 1'b0; committed_q[i] <= 1'b0;
      end
      st_ready_q <= 1'b0; st_lab_q <= '0; lsb_ready_q <= 1'b0; lsb_lab_q <= '0;
      lsb_val_q <= '0; mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= '0;
      mem_wdata_q <= '0; mem_size_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d; head_q <= head_d; tail_q <= tail_d; count_q <= count_d;
      ccnt_q <= ccnt_d; drop_q <= drop_d; busy_store_q <= busy_store_d;
      is_store_q <= is_store_d; funct3_q <= funct3_d; tag_q <= tag_d; imm_q <= imm_d;
      rdy1_q <= rdy1_d; val1_q <= val1_d; lab1_q <= lab1_d;
      rdy2_q <= rdy2_d; val2_q <= val2_d; lab2_q <= lab2_d;
      announced_q <= announced_d; committed_q <= committed_d;
      st_ready_q <= st_ready_d; st_lab_q <= st_lab_d; lsb_ready_q <= lsb_ready_d;
      lsb_lab_q <= lsb_lab_d; lsb_val_q <= lsb_val_d; mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      mem_size_q <= mem_size_d;
    end
  end

  assign st_ready  = st_ready_q;
  assign st_lab    = st_lab_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign lsb_ready = lsb_ready_q;
  assign lsb_lab   = lsb_lab_q;
  assign lsb_val   = lsb_val_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// Scoreboard bench for load_store_buffer: stimulus pushes expected requests and results,
// monitors on the falling edge pop and compare whenever the DUT presents them.
module tb_load_store_buffer;

  logic        clk = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
  logic        issue_valid = 1'b0, issue_is_store = 1'b0, issue_ready1 = 1'b0, issue_ready2 = 1'b0;
  logic [2:0]  issue_funct3 = '0;
  logic [3:0]  issue_tag = '0, issue_lab1 = '0, issue_lab2 = '0;
  logic [31:0] issue_imm = '0, issue_val1 = '0, issue_val2 = '0;
  logic        lsbFull, cdbReady = 1'b0, aluReady = 1'b0, commit_valid = 1'b0;
  logic [3:0]  cdb2lab = '0, entry_in = '0, commit_lab = '0;
  logic [31:0] cdb2val = '0, val_in = '0;
  logic        st_ready, mem_req, mem_we, mem_done = 1'b0, lsb_ready;
  logic [3:0]  st_lab, lsb_lab;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, lsb_val;
  logic [1:0]  mem_size;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; } mreq_t;
  typedef struct { logic [3:0] tag; logic [31:0] val; } lres_t;
  mreq_t       exp_mem[$];
  lres_t       exp_lsb[$];
  logic [3:0]  exp_st[$];
  logic [31:0] rdata_q[$];
  int          lat = 2;
  int          checks = 0, failures = 0;

  load_store_buffer #(.LSB_SIZE(8), .ID_WIDTH(4), .VAL_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .issue_valid(issue_valid), .issue_is_store(issue_is_store), .issue_funct3(issue_funct3),
    .issue_tag(issue_tag), .issue_imm(issue_imm), .issue_ready1(issue_ready1),
    .issue_ready2(issue_ready2), .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_lab1(issue_lab1), .issue_lab2(issue_lab2), .lsbFull(lsbFull),
    .cdbReady(cdbReady), .cdb2lab(cdb2lab), .cdb2val(cdb2val),
    .aluReady(aluReady), .entry_in(entry_in), .val_in(val_in),
    .commit_valid(commit_valid), .commit_lab(commit_lab),
    .st_ready(st_ready), .st_lab(st_lab), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsb_ready(lsb_ready), .lsb_lab(lsb_lab), .lsb_val(lsb_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  task automatic issue_op(input logic st, input logic [2:0] f3, input logic [3:0] tag,
                          input logic [31:0] imm, input logic r1, input logic [31:0] v1,
                          input logic [3:0] l1, input logic r2, input logic [31:0] v2,
                          input logic [3:0] l2);
    issue_is_store = st; issue_funct3 = f3; issue_tag = tag; issue_imm = imm;
    issue_ready1 = r1; issue_val1 = v1; issue_lab1 = l1;
    issue_ready2 = r2; issue_val2 = v2; issue_lab2 = l2;
    issue_valid = 1'b1;
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  // Ready load with its full expected request and result.
  task automatic load(input logic [3:0] tag, input logic [2:0] f3, input logic [31:0] imm,
                      input logic [31:0] v1, input logic [31:0] rd, input logic [31:0] ev);
    exp_mem.push_back('{we: 1'b0, addr: v1 + imm, wdata: 32'h0, size: f3[1:0]});
    rdata_q.push_back(rd);
    exp_lsb.push_back('{tag: tag, val: ev});
    issue_op(1'b0, f3, tag, imm, 1'b1, v1, 4'h0, 1'b1, 32'h0, 4'h0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (((exp_lsb.size() + exp_mem.size() + exp_st.size()) != 0 || mem_req) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(name, 64'(exp_lsb.size() + exp_mem.size() + exp_st.size()), 64'h0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'h0, mem_req}, 64'h1);
  endtask

  // Memory model: answers each request after lat cycles with the next queued rdata.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && rst_in) begin
        repeat (lat - 1) @(negedge clk);
        mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
      end
    end
  end

  // Monitor.
  initial begin
    logic  prev_req;
    mreq_t cur;
    lres_t l;
    logic [3:0] s;
    prev_req = 1'b0;
    cur = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, size: 2'h0};
    forever begin
      @(negedge clk);
      if (rst_in) begin
        if (lsb_ready) begin
          if (exp_lsb.size() == 0) unexpected("lsb_ready");
          else begin
            l = exp_lsb.pop_front();
            check("lsb_lab", {60'h0, lsb_lab}, {60'h0, l.tag});
            check("lsb_val", {32'h0, lsb_val}, {32'h0, l.val});
          end
        end
        if (st_ready) begin
          if (exp_st.size() == 0) unexpected("st_ready");
          else begin
            s = exp_st.pop_front();
            check("st_lab", {60'h0, st_lab}, {60'h0, s});
          end
        end
        if (mem_req && !prev_req) begin
          cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, size: mem_size};
          if (exp_mem.size() == 0) unexpected("mem_req");
          else begin
            mreq_t e;
            e = exp_mem.pop_front();
            check("mem_we", {63'h0, mem_we}, {63'h0, e.we});
            check("mem_addr", {32'h0, mem_addr}, {32'h0, e.addr});
            check("mem_size", {62'h0, mem_size}, {62'h0, e.size});
            if (e.we) check("mem_wdata", {32'h0, mem_wdata}, {32'h0, e.wdata});
          end
        end else if (mem_req) begin
          check("mem_stable", {mem_we, mem_size, 29'h0, mem_addr},
                {cur.we, cur.size, 29'h0, cur.addr});
          check("mem_wdata_stable", {32'h0, mem_wdata}, {32'h0, cur.wdata});
        end
      end
      prev_req = mem_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_flags", {58'h0, lsbFull, st_ready, mem_req, mem_we, lsb_ready, 1'b0}, 64'h0);
    check("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    check("rst_size_labs", {54'h0, mem_size, st_lab, lsb_lab}, 64'h0);
    check("rst_lsb_val", {32'h0, lsb_val}, 64'h0);
    rst_in = 1'b1;
    @(negedge clk);

    // LW with one-cycle launch latency after the issue edge.
    load(4'd3, 3'b010, 32'h4, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    check("lw_latency", {63'h0, mem_req}, 64'h0);
    drain("drain_lw");

    // Sign/zero extension variants.
    load(4'd1, 3'b000, 32'h0, 32'h200, 32'h00000080, 32'hFFFFFF80);
    load(4'd2, 3'b100, 32'h1, 32'h200, 32'h00000080, 32'h00000080);
    load(4'd4, 3'b101, 32'h2, 32'h200, 32'h00008001, 32'h00008001);
    load(4'd6, 3'b001, 32'h6, 32'h200, 32'h00008001, 32'hFFFF8001);
    drain("drain_ext");

    // Store waiting on ALU data, then on commit.
    exp_st.push_back(4'd5);
    issue_op(1'b1, 3'b010, 4'd5, 32'h0, 1'b1, 32'h40, 4'h0, 1'b0, 32'h0, 4'd7);
    aluReady = 1'b1; entry_in = 4'd7; val_in = 32'h55;
    @(negedge clk);
    aluReady = 1'b0;
    repeat (6) @(negedge clk);
    check("st_no_req_before_commit", {63'h0, mem_req}, 64'h0);
    check("st_announced_once", 64'(exp_st.size()), 64'h0);
    exp_mem.push_back('{we: 1'b1, addr: 32'h40, wdata: 32'h55, size: 2'd2});
    rdata_q.push_back(32'h0);
    commit_valid = 1'b1; commit_lab = 4'd5;
    @(negedge clk);
    commit_valid = 1'b0;
    drain("drain_store");

    // Fill to capacity, drop the 9th issue, release all and drain across the wrap.
    for (int i = 0; i < 8; i++) begin
      issue_op(1'b0, 3'b010, 4'(i), 32'(i * 4), 1'b0, 32'h0, 4'd15, 1'b1, 32'h0, 4'h0);
    end
    check("full_after_8", {63'h0, lsbFull}, 64'h1);
    issue_op(1'b0, 3'b010, 4'd8, 32'h0, 1'b1, 32'h500, 4'h0, 1'b1, 32'h0, 4'h0);
    check("full_after_9th", {63'h0, lsbFull}, 64'h1);
    for (int i = 0; i < 8; i++) begin
      exp_mem.push_back('{we: 1'b0, addr: 32'h1000 + 32'(i * 4), wdata: 32'h0, size: 2'd2});
      rdata_q.push_back(32'hA0000000 + 32'(i));
      exp_lsb.push_back('{tag: 4'(i), val: 32'hA0000000 + 32'(i)});
    end
    cdbReady = 1'b1; cdb2lab = 4'd15; cdb2val = 32'h1000;
    @(negedge clk);
    cdbReady = 1'b0;
    drain("drain_full");
    check("not_full_after_drain", {63'h0, lsbFull}, 64'h0);

    // Flush with a committed store in flight and three younger loads behind it.
    lat = 8;
    exp_st.push_back(4'd6);
    issue_op(1'b1, 3'b010, 4'd6, 32'h0, 1'b1, 32'h80, 4'h0, 1'b1, 32'h1234, 4'h0);
    for (int k = 0; k < 3; k++) begin
      issue_op(1'b0, 3'b010, 4'(9 + k), 32'h0, 1'b0, 32'h0, 4'd14, 1'b1, 32'h0, 4'h0);
    end
    exp_mem.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h1234, size: 2'd2});
    rdata_q.push_back(32'h0);
    commit_valid = 1'b1; commit_lab = 4'd6;
    @(negedge clk);
    commit_valid = 1'b0;
    wait_req("flush_store_req");
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    drain("drain_flush_store");
    lat = 2;
    load(4'd12, 3'b010, 32'h0, 32'h300, 32'h00000077, 32'h00000077);
    drain("drain_after_flush");

    // Same-cycle CDB capture at issue.
    exp_mem.push_back('{we: 1'b0, addr: 32'h208, wdata: 32'h0, size: 2'd2});
    rdata_q.push_back(32'hCAFE0000);
    exp_lsb.push_back('{tag: 4'd13, val: 32'hCAFE0000});
    cdbReady = 1'b1; cdb2lab = 4'd2; cdb2val = 32'h200;
    issue_op(1'b0, 3'b010, 4'd13, 32'h8, 1'b0, 32'h0, 4'd2, 1'b1, 32'h0, 4'h0);
    cdbReady = 1'b0;
    @(negedge clk);
    check("cdb_issue_req", {63'h0, mem_req}, 64'h1);
    check("cdb_issue_addr", {32'h0, mem_addr}, 64'h208);
    drain("drain_cdb_issue");

    // rdy_in low: an issue must not be accepted.
    rdy_in = 1'b0;
    issue_op(1'b0, 3'b010, 4'd4, 32'h0, 1'b1, 32'h10, 4'h0, 1'b1, 32'h0, 4'h0);
    issue_op(1'b0, 3'b010, 4'd4, 32'h0, 1'b1, 32'h10, 4'h0, 1'b1, 32'h0, 4'h0);
    check("freeze_no_req", {63'h0, mem_req}, 64'h0);
    rdy_in = 1'b1;
    repeat (4) @(negedge clk);
    check("freeze_no_late_req", {63'h0, mem_req}, 64'h0);

    // Reset in the middle of a load.
    lat = 10;
    exp_mem.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, size: 2'd2});
    rdata_q.push_back(32'h99);
    issue_op(1'b0, 3'b010, 4'd1, 32'h10, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0);
    wait_req("rst_mid_req");
    rst_in = 1'b0;
    @(negedge clk);
    check("rst_mid_drops_req", {63'h0, mem_req}, 64'h0);
    rst_in = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_mid_no_result", {63'h0, lsb_ready}, 64'h0);
    drain("drain_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
